// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with fixed lowest-index-first priority.
// One request at a time: IDLE arbitrates, ASSERT waits for ack, SERVICE waits for EOI.
module irq_controller #(
   parameter int NUM_SRC = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_SRC-1:0]  irq_src,
   input  logic                cfg_write,
   input  logic [1:0]          cfg_addr,
   input  logic [15:0]         cfg_wdata,
   output logic [15:0]         cfg_rdata,
   output logic                irq,
   output logic [15:0]         irq_vector,
   input  logic                reset_irq,
   output logic [1:0]          fsm_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_MASK    = 2'd0;
   localparam logic [1:0] ADDR_PENDING = 2'd1;
   localparam logic [1:0] ADDR_BASE    = 2'd2;
   localparam logic [1:0] ADDR_EOI     = 2'd3;

   state_t               state;
   logic [NUM_SRC-1:0]   sync_1;
   logic [NUM_SRC-1:0]   sync_2;
   logic [NUM_SRC-1:0]   history;
   logic [NUM_SRC-1:0]   mask;
   logic [NUM_SRC-1:0]   pending;
   logic [15:0]          vector_base;
   logic [2:0]           active_idx;
   logic                 in_service;

   logic [NUM_SRC-1:0]   edge_seen;
   logic [NUM_SRC-1:0]   clear_bits;
   logic [NUM_SRC-1:0]   eligible;
   logic [2:0]           winner_idx;
   logic                 ack_fire;
   logic                 eoi_write;

   assign edge_seen = sync_2 & ~history;
   assign eligible  = pending & mask;
   assign ack_fire  = (state == ASSERT) && reset_irq;
   assign eoi_write = cfg_write && (cfg_addr == ADDR_EOI);

   // Walk downward so the lowest set index is the last one assigned.
   always_comb begin
      winner_idx = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner_idx = 3'(i);
      end
   end

   always_comb begin
      clear_bits = '0;
      if (cfg_write && (cfg_addr == ADDR_PENDING)) clear_bits = cfg_wdata[NUM_SRC-1:0];
      if (ack_fire) clear_bits[active_idx] = 1'b1;
   end

   // A fresh edge wins over any clear landing in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_1      <= '0;
         sync_2      <= '0;
         history     <= '0;
         pending     <= '0;
         mask        <= '0;
         vector_base <= '0;
      end else begin
         sync_1  <= irq_src;
         sync_2  <= sync_1;
         history <= sync_2;
         pending <= (pending & ~clear_bits) | edge_seen;
         if (cfg_write && (cfg_addr == ADDR_MASK)) mask <= cfg_wdata[NUM_SRC-1:0];
         if (cfg_write && (cfg_addr == ADDR_BASE)) vector_base <= cfg_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         irq        <= 1'b0;
         active_idx <= 3'd0;
         in_service <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|eligible) begin
                  active_idx <= winner_idx;
                  irq        <= 1'b1;
                  state      <= ASSERT;
               end
            end
            ASSERT: begin
               if (reset_irq) begin
                  irq        <= 1'b0;
                  in_service <= 1'b1;
                  state      <= SERVICE;
               end
            end
            SERVICE: begin
               if (eoi_write) begin
                  in_service <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               irq        <= 1'b0;
               in_service <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   // Follows vector_base live so a base rewrite during ASSERT shows up next cycle.
   assign irq_vector = vector_base + {11'd0, active_idx, 2'b00};
   assign fsm_state  = state;

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         ADDR_MASK:    cfg_rdata = {{(16 - NUM_SRC){1'b0}}, mask};
         ADDR_PENDING: cfg_rdata = {{(16 - NUM_SRC){1'b0}}, pending};
         ADDR_BASE:    cfg_rdata = vector_base;
         ADDR_EOI:     cfg_rdata = {12'h000, in_service, active_idx};
         default:      cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: latency, priority, masking, W1C, vector wrap,
// set-wins races and asynchronous reset behaviour.
module tb_irq_controller;

   logic        clock;
   logic        reset;
   logic [7:0]  irq_src;
   logic        cfg_write;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [15:0] cfg_rdata;
   logic        irq;
   logic [15:0] irq_vector;
   logic        reset_irq;
   logic [1:0]  fsm_state;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_q[$];

   irq_controller #(.NUM_SRC(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .irq_src    (irq_src),
      .cfg_write  (cfg_write),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .irq        (irq),
      .irq_vector (irq_vector),
      .reset_irq  (reset_irq),
      .fsm_state  (fsm_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [15:0] data);
      cfg_write = 1'b1;
      cfg_addr  = addr;
      cfg_wdata = data;
      @(negedge clock);
      cfg_write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] addr, input logic [15:0] exp, input string tag);
      cfg_addr = addr;
      #1;
      check(tag, cfg_rdata, exp);
   endtask

   task automatic ack();
      reset_irq = 1'b1;
      @(negedge clock);
      reset_irq = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      irq_src   = '0;
      cfg_write = 1'b0;
      cfg_addr  = 2'd0;
      cfg_wdata = '0;
      reset_irq = 1'b0;
      #3;
      check("rst_irq", {15'd0, irq}, 16'd0);
      check("rst_vector", irq_vector, 16'h0000);
      rd(2'd0, 16'h0000, "rst_mask");
      rd(2'd1, 16'h0000, "rst_pending");
      rd(2'd2, 16'h0000, "rst_base");
      rd(2'd3, 16'h0000, "rst_status");
      @(negedge clock);
      reset = 1'b1;

      // Single source: latency, vector, ack, status readback
      wr(2'd0, 16'h0004);
      wr(2'd2, 16'h0100);
      irq_src[2] = 1'b1;
      cyc(3);
      check("t1_irq_before_e4", {15'd0, irq}, 16'd0);
      rd(2'd1, 16'h0004, "t1_pending_after_e3");
      cyc(1);
      check("t1_irq_after_e4", {15'd0, irq}, 16'd1);
      check("t1_vector", irq_vector, 16'h0108);
      check("t1_state_assert", {14'd0, fsm_state}, 16'd1);
      irq_src[2] = 1'b0;
      ack();
      check("t1_irq_after_ack", {15'd0, irq}, 16'd0);
      rd(2'd1, 16'h0000, "t1_pending_cleared");
      rd(2'd3, 16'h000A, "t1_status_service");
      wr(2'd3, 16'h1234);
      rd(2'd3, 16'h0002, "t1_status_after_eoi");
      check("t1_state_idle", {14'd0, fsm_state}, 16'd0);

      // Simultaneous edges: index 1 before index 5
      wr(2'd0, 16'h00FF);
      exp_q.push_back(16'h0104);
      exp_q.push_back(16'h0114);
      irq_src = 8'h22;
      cyc(4);
      check("t2_irq_first", {15'd0, irq}, 16'd1);
      check("t2_vector_first", irq_vector, exp_q.pop_front());
      irq_src = 8'h00;
      ack();
      rd(2'd1, 16'h0020, "t2_pending_left");
      wr(2'd3, 16'h0000);
      cyc(1);
      check("t2_irq_second", {15'd0, irq}, 16'd1);
      check("t2_vector_second", irq_vector, exp_q.pop_front());
      ack();
      wr(2'd3, 16'h0000);
      rd(2'd1, 16'h0000, "t2_pending_empty");

      // Masked source, ignored ack, late unmask, commitment in ASSERT
      wr(2'd0, 16'h0000);
      irq_src[3] = 1'b1;
      cyc(4);
      rd(2'd1, 16'h0008, "t3_pending_masked");
      check("t3_irq_masked", {15'd0, irq}, 16'd0);
      irq_src[3] = 1'b0;
      ack();
      rd(2'd1, 16'h0008, "t3_ack_in_idle_ignored");
      wr(2'd0, 16'h0008);
      cyc(1);
      check("t3_irq_unmasked", {15'd0, irq}, 16'd1);
      check("t3_vector", irq_vector, 16'h010C);
      wr(2'd0, 16'hFF00);
      rd(2'd0, 16'h0000, "t3_mask_high_byte_ignored");
      wr(2'd1, 16'h0008);
      rd(2'd1, 16'h0000, "t3_w1c_in_assert");
      check("t3_irq_committed", {15'd0, irq}, 16'd1);
      wr(2'd2, 16'h0200);
      check("t3_vector_rebased", irq_vector, 16'h020C);
      ack();
      wr(2'd3, 16'h0000);
      irq_src[3] = 1'b1;
      cyc(4);
      rd(2'd1, 16'h0008, "t3_pending_again");
      irq_src[3] = 1'b0;
      wr(2'd1, 16'h0008);
      rd(2'd1, 16'h0000, "t3_w1c_idle");

      // Vector wrap and re-edge racing the ack clear
      wr(2'd2, 16'hFFFC);
      wr(2'd0, 16'h0080);
      irq_src[7] = 1'b1;
      cyc(4);
      check("t4_irq", {15'd0, irq}, 16'd1);
      check("t4_vector_wrap", irq_vector, 16'h0018);
      irq_src[7] = 1'b0;
      cyc(3);
      irq_src[7] = 1'b1;
      cyc(2);
      ack();
      irq_src[7] = 1'b0;
      rd(2'd1, 16'h0080, "t4_set_wins_over_ack");
      check("t4_irq_low", {15'd0, irq}, 16'd0);
      check("t4_state_service", {14'd0, fsm_state}, 16'd2);

      // Edge during SERVICE, then asynchronous reset mid-SERVICE
      wr(2'd1, 16'h0080);
      rd(2'd1, 16'h0000, "t5_w1c_service");
      irq_src[0] = 1'b1;
      cyc(3);
      rd(2'd1, 16'h0001, "t5_edge_in_service");
      #1;
      reset = 1'b0;
      #1;
      check("t5_rst_irq", {15'd0, irq}, 16'd0);
      check("t5_rst_state", {14'd0, fsm_state}, 16'd0);
      rd(2'd0, 16'h0000, "t5_rst_mask");
      rd(2'd1, 16'h0000, "t5_rst_pending");
      rd(2'd2, 16'h0000, "t5_rst_base");
      rd(2'd3, 16'h0000, "t5_rst_status");
      @(negedge clock);
      reset = 1'b1;
      ack();
      wr(2'd3, 16'h0000);
      cyc(1);
      rd(2'd1, 16'h0001, "t5_held_src_edge");
      rd(2'd3, 16'h0000, "t5_status_after_ignored");
      check("t5_irq_idle", {15'd0, irq}, 16'd0);
      wr(2'd1, 16'h0001);
      cyc(3);
      rd(2'd1, 16'h0000, "t5_single_edge_only");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
